// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory bus bundle for dmem_arbiter
interface dmem_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_lock;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // requesters plus memory side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with starvation guard and bounded lock
module dmem_arbiter #(
  parameter int DEPTH        = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic {OPEN, LOCKED} lock_state_t;

  lock_state_t   state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [LW-1:0] lock_cnt, lock_cnt_nxt;
  logic          g0, g1;
  logic          in0, in1;

  assign in0 = bus.m0_addr < 32'(DEPTH);
  assign in1 = bus.m1_addr < 32'(DEPTH);

  // Grant selection: held lock (unless port 0 has waited out a full burst),
  // then starvation relief, then port 0 priority, then port 1.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      g0 = 1'b0;
      g1 = 1'b0;
    end else if (bus.m1_req && state == LOCKED &&
                 !(bus.m0_req && lock_cnt == LW'(LOCK_MAX))) begin
      g1 = 1'b1;
    end else if (bus.m1_req && starve_cnt == SW'(STARVE_LIMIT)) begin
      g1 = 1'b1;
    end else if (bus.m0_req) begin
      g0 = 1'b1;
    end else if (bus.m1_req) begin
      g1 = 1'b1;
    end
  end

  assign bus.m0_gnt = g0;
  assign bus.m1_gnt = g1;

  // Memory drive: granted port's bus, zeros when idle, out-of-range writes dropped.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (g0) begin
      bus.mem_we    = bus.m0_we & in0;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
    end else if (g1) begin
      bus.mem_we    = bus.m1_we & in1;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
    end
  end

  // Next lock state, starvation count and locked-burst length.
  always_comb begin
    state_nxt    = state;
    starve_nxt   = '0;
    lock_cnt_nxt = '0;
    // A forced port-0 slot leaves the lock in place so port 1 resumes next cycle.
    if (!bus.m1_req) begin
      state_nxt = OPEN;
    end else if (g1) begin
      state_nxt = bus.m1_lock ? LOCKED : OPEN;
    end
    if (bus.m1_req && !g1) begin
      starve_nxt = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + SW'(1);
    end
    if (g1 && state == LOCKED && bus.m0_req) begin
      lock_cnt_nxt = lock_cnt + LW'(1);
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OPEN;
      starve_cnt <= '0;
      lock_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      lock_cnt   <= lock_cnt_nxt;
    end
  end

  // Registered responses: one-cycle rvalid/err pulses, rdata held until next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.m0_rvalid <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rvalid <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m1_rdata  <= '0;
    end else begin
      bus.m0_rvalid <= g0 & ~bus.m0_we;
      bus.m0_err    <= g0 & ~in0;
      if (g0 && !bus.m0_we) begin
        bus.m0_rdata <= in0 ? bus.mem_rdata : '0;
      end
      bus.m1_rvalid <= g1 & ~bus.m1_we;
      bus.m1_err    <= g1 & ~in1;
      if (g1 && !bus.m1_we) begin
        bus.m1_rdata <= in1 ? bus.mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench with behavioural arbiter model for dmem_arbiter
module tb_dmem_arbiter;
  localparam int DEPTH        = 1024;
  localparam int STARVE_LIMIT = 4;
  localparam int LOCK_MAX     = 8;

  logic clk;
  logic rst;
  dmem_arbiter_if bus();

  dmem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: combinational read, write at posedge.
  logic [31:0] mem [0:DEPTH-1];
  bit          mem_ready = 1'b0;
  assign bus.mem_rdata = (bus.mem_addr < 32'(DEPTH)) ? mem[bus.mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i + 30);
      mem_ready <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end
  end

  int phase = 0;
  bit done  = 1'b0;
  int total = 0;
  int bad   = 0;

  int pat2[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
  int pat4[14] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model state, written in terms of what each requester has experienced.
  logic [31:0] shadow [0:DEPTH-1];
  bit          shadow_ready = 1'b0;
  int          m1_denied;
  bit          m1_held;
  int          held_while_m0_waits;
  logic        e_rv0, e_err0, e_rv1, e_err1;
  logic [31:0] e_rd0, e_rd1;
  int          last_phase = -1;
  int          pc;
  int          w0, max_w0;

  always @(negedge clk) begin
    int          who, gc;
    logic        e_we;
    logic [31:0] e_addr, e_wdata;
    logic        w_we, w_in;
    logic [31:0] w_addr, w_wdata;

    if (phase != last_phase) begin
      pc = 0;
      last_phase = phase;
    end else begin
      pc++;
    end
    if (!shadow_ready) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] = 32'(i + 30);
      shadow_ready = 1'b1;
      max_w0 = 0;
    end
    gc = bus.m0_gnt ? 1 : (bus.m1_gnt ? 2 : 0);

    if (rst) begin
      chk("rst_m0_gnt", {31'b0, bus.m0_gnt}, 0);
      chk("rst_m1_gnt", {31'b0, bus.m1_gnt}, 0);
      chk("rst_mem_we", {31'b0, bus.mem_we}, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_m0_rvalid", {31'b0, bus.m0_rvalid}, 0);
      chk("rst_m0_err", {31'b0, bus.m0_err}, 0);
      chk("rst_m0_rdata", bus.m0_rdata, 0);
      chk("rst_m1_rvalid", {31'b0, bus.m1_rvalid}, 0);
      chk("rst_m1_err", {31'b0, bus.m1_err}, 0);
      chk("rst_m1_rdata", bus.m1_rdata, 0);
      m1_denied = 0;
      m1_held = 1'b0;
      held_while_m0_waits = 0;
      e_rv0 = 0; e_err0 = 0; e_rd0 = 0;
      e_rv1 = 0; e_err1 = 0; e_rd1 = 0;
      w0 = 0;
    end else begin
      chk("m0_rvalid", {31'b0, bus.m0_rvalid}, {31'b0, e_rv0});
      chk("m0_err", {31'b0, bus.m0_err}, {31'b0, e_err0});
      chk("m0_rdata", bus.m0_rdata, e_rd0);
      chk("m1_rvalid", {31'b0, bus.m1_rvalid}, {31'b0, e_rv1});
      chk("m1_err", {31'b0, bus.m1_err}, {31'b0, e_err1});
      chk("m1_rdata", bus.m1_rdata, e_rd1);

      // Who is entitled to the memory this cycle.
      if (bus.m1_req && m1_held && !(bus.m0_req && held_while_m0_waits >= LOCK_MAX)) who = 2;
      else if (bus.m1_req && m1_denied >= STARVE_LIMIT) who = 2;
      else if (bus.m0_req) who = 1;
      else if (bus.m1_req) who = 2;
      else who = 0;

      w_we = 0; w_addr = 0; w_wdata = 0;
      if (who == 1) begin
        w_we = bus.m0_we; w_addr = bus.m0_addr; w_wdata = bus.m0_wdata;
      end else if (who == 2) begin
        w_we = bus.m1_we; w_addr = bus.m1_addr; w_wdata = bus.m1_wdata;
      end
      w_in = (w_addr < 32'(DEPTH));
      e_we = (who != 0) && w_we && w_in;
      e_addr = w_addr;
      e_wdata = w_wdata;

      chk("gnt_owner", 32'(gc), 32'(who));
      chk("m0_and_m1_gnt", {31'b0, bus.m0_gnt & bus.m1_gnt}, 0);
      chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e_we});
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_wdata", bus.mem_wdata, e_wdata);

      // Responses that should appear after the coming edge.
      e_rv0 = (who == 1) && !w_we;
      e_err0 = (who == 1) && !w_in;
      if (who == 1 && !w_we) e_rd0 = w_in ? shadow[w_addr[9:0]] : 32'h0;
      e_rv1 = (who == 2) && !w_we;
      e_err1 = (who == 2) && !w_in;
      if (who == 2 && !w_we) e_rd1 = w_in ? shadow[w_addr[9:0]] : 32'h0;
      if (e_we) shadow[w_addr[9:0]] = w_wdata;

      if (!bus.m1_req || who == 2) m1_denied = 0;
      else if (m1_denied < STARVE_LIMIT) m1_denied++;
      held_while_m0_waits = (who == 2 && m1_held && bus.m0_req) ? held_while_m0_waits + 1 : 0;
      m1_held = bus.m1_req && ((who == 2) ? bus.m1_lock : m1_held);

      // Hand-computed expectations for the directed scenarios.
      if (phase == 1 && pc == 0) chk("p1_m1_gnt", {31'b0, bus.m1_gnt}, 1);
      if (phase == 1 && pc == 1) begin
        chk("p1_m1_rvalid", {31'b0, bus.m1_rvalid}, 1);
        chk("p1_m1_rdata", bus.m1_rdata, 32'd64);
        chk("p1_m1_err", {31'b0, bus.m1_err}, 0);
      end
      if (phase == 2 && pc < 10) chk($sformatf("p2_owner_%0d", pc), 32'(gc), 32'(pat2[pc]));
      if (phase == 3 && pc == 0) chk("p3_m0_first", 32'(gc), 1);
      if (phase == 3 && pc == 1) chk("p3_m1_next", 32'(gc), 2);
      if (phase == 3 && pc == 2) chk("p3_m1_rdata", bus.m1_rdata, 32'hDEADBEEF);
      if (phase == 4 && pc < 14) chk($sformatf("p4_owner_%0d", pc), 32'(gc), 32'(pat4[pc]));
      if (phase == 4 && pc == 9) chk("p4_m0_wait", 32'(w0), 32'd8);
      if (phase == 5 && pc == 0) chk("p5_wr1024_mem_we", {31'b0, bus.mem_we}, 0);
      if (phase == 5 && pc == 1) chk("p5_m0_err_pulse", {31'b0, bus.m0_err}, 1);
      if (phase == 5 && pc == 2) begin
        chk("p5_rd1023_err", {31'b0, bus.m0_err}, 0);
        chk("p5_rd1023_rdata", bus.m0_rdata, 32'd1053);
      end
      if (phase == 5 && pc == 3) begin
        chk("p5_hi_addr_err", {31'b0, bus.m1_err}, 1);
        chk("p5_hi_addr_rdata", bus.m1_rdata, 0);
      end
      if (phase == 6 && pc == 5) chk("p6_m0_first_after_rst", 32'(gc), 1);

      w0 = (bus.m0_req && !bus.m0_gnt) ? w0 + 1 : 0;
      if (w0 > max_w0) max_w0 = w0;
    end

    if (phase == 6 && pc == 3) chk("p6_rst_clears_m1_rvalid", {31'b0, bus.m1_rvalid}, 0);

    if (done) begin
      chk("max_m0_wait", 32'(max_w0 <= LOCK_MAX), 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0; bus.m1_lock = 0;
    step(3);
    rst = 1'b0;
    step(1);

    // m1 read of address 34
    phase = 1;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 34;
    step(1);
    bus.m1_req = 0;
    step(2);

    // both ports request continuously, no lock
    phase = 2;
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 1;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 2; bus.m1_lock = 0;
    step(10);
    bus.m0_req = 0; bus.m1_req = 0;
    step(1);

    // m0 write then m1 read of the same word
    phase = 3;
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 10; bus.m0_wdata = 32'hDEADBEEF;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 10;
    step(1);
    bus.m0_req = 0; bus.m0_we = 0;
    step(1);
    bus.m1_req = 0;
    step(2);

    // locked m1 burst of 12 reads against a continuously requesting m0
    phase = 4;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 200; bus.m1_lock = 1;
    step(1);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 5;
    step(12);
    bus.m1_req = 0; bus.m1_lock = 0;
    step(1);
    bus.m0_req = 0;
    step(2);

    // address range boundaries
    phase = 5;
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 1024; bus.m0_wdata = 5;
    step(1);
    bus.m0_we = 0; bus.m0_addr = 1023;
    step(1);
    bus.m0_req = 0;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h8000_0000;
    step(1);
    bus.m1_req = 0;
    step(2);

    // reset in the middle of a locked burst
    phase = 6;
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 300; bus.m1_lock = 1;
    step(1);
    bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 7;
    step(2);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    bus.m0_req = 0; bus.m1_req = 0; bus.m1_lock = 0;
    step(2);
    done = 1'b1;
    step(3);
    $display("FAIL summary_not_reached actual=0 required=1");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 1K-word data memory between two requesters:
  - Port 0: pipeline MEM stage.
  - Port 1: loader/debug port.
- Memory-side behaviour it drives: writes commit at posedge clk, reads are combinational.
- Arbiter behaviour:
  - One access granted per cycle; port 0 has priority.
  - Port 1 is protected from starvation and may lock the memory for bounded bursts.
  - Read data, completion and errors are returned as registered responses one cycle later.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data memory; legal addresses 0..DEPTH-1.
- STARVE_LIMIT, 4, consecutive denied cycles after which a waiting port 1 is granted ahead of port 0.
- LOCK_MAX, 8, maximum consecutive locked grants to port 1 while port 0 is requesting.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  port 0 access request, held until granted.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  32  port 0 word address.
- m0_wdata  in  32  port 0 write data.
- m0_gnt  out  1  combinational; access performed this cycle.
- m0_rvalid  out  1  registered; read response valid.
- m0_rdata  out  32  registered read data.
- m0_err  out  1  registered; out-of-range access response.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as port 0, for port 1.
- m1_lock  in  1  port 1 requests to retain the grant next cycle.
- mem_we  out  1  write enable to data memory.
- mem_addr  out  32  address to data memory.
- mem_wdata  out  32  write data to data memory.
- mem_rdata  in  32  combinational read data from data memory.

Behaviour:
- Reset (async, rst=1):
  - m*_rvalid, m*_err and m*_rdata clear to 0.
  - starve_cnt=0, lock_r=0, lock_cnt=0.
  - While rst is high, m*_gnt=0, mem_we=0, mem_addr=0 and mem_wdata=0.
  - Reset mid-burst or mid-wait abandons the access; no write is issued.
- Grant selection, combinational, evaluated in priority order:
  1. m1_req & lock_r & ~(m0_req & lock_cnt==LOCK_MAX) -> port 1.
  2. m1_req & starve_cnt==STARVE_LIMIT -> port 1.
  3. m0_req -> port 0.
  4. m1_req -> port 1.
  5. Otherwise idle.
  - Exactly one gnt at most per cycle.
- Memory drive:
  - The granted port's addr and wdata go to the memory.
  - Idle drives mem_addr=0 and mem_wdata=0.
  - mem_we = gnt & we & (addr < DEPTH).
  - Out-of-range writes are suppressed.
- Responses, registered at the posedge ending the grant cycle:
  - Granted read: rdata <= in-range ? mem_rdata : 0; rvalid <= 1.
  - Granted write: rvalid stays 0.
  - Any granted out-of-range access: err <= 1.
  - rvalid and err are single-cycle pulses; rdata holds its value until the next read response on that port.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when m1_req & ~m1_gnt.
  - Clears when m1_gnt or ~m1_req.
- Lock:
  - lock_r <= m1_gnt & m1_lock.
  - lock_r clears when m1_req drops or a grant has m1_lock=0.
  - lock_cnt increments on each locked m1 grant while m0_req=1, and clears otherwise.
  - On reaching LOCK_MAX, one grant is forced to port 0; lock_r is kept, so port 1 resumes the next cycle.
- Port 0 stall: the pipeline stalls on m0_req & ~m0_gnt, so that condition is the stall signal. Worst-case port 0 wait is LOCK_MAX cycles.
- Simultaneous requests with no lock and no starvation: port 0 wins.
- Address is a word index, with no byte-lane handling.
- Boundaries:
  - addr = DEPTH-1 is legal.
  - addr = DEPTH is an error.
  - Upper address bits set (e.g. 0x8000_0000) is an error.

Test Plan:
- Reset then m1 read addr 34 -> m1_gnt same cycle; next cycle m1_rvalid=1, m1_rdata=64, m1_err=0.
- Both ports request every cycle, m1_lock=0, STARVE_LIMIT=4:
  - Grants go m0,m0,m0,m0,m1, then repeat.
  - starve_cnt returns to 0 after the m1 grant.
- m0 write addr 10 data 0xDEADBEEF, then m1 read addr 10 -> m1_rdata=0xDEADBEEF. Same-cycle requests resolve to m0 first, m1 granted the next cycle.
- m1 locked burst of 12 reads with m0_req held high, LOCK_MAX=8:
  - m1 gets 8 grants, then m0 gets 1, then m1 resumes.
  - m0 waits no more than 8 cycles.
- m0 write addr 1024 data 5 -> mem_we=0 and m0_err pulses. Follow-up read of addr 1023 -> m0_err=0.
- Assert rst during a locked m1 burst:
  - All gnt and mem_we drop immediately; rvalid/err=0.
  - After release, m0 is granted first.
